// File: rtl/runner_pkg.sv
// Shared types for the frame runner: scheduler state encoding and the
// framebuffer pixel-write record at the default framebuffer geometry.
package runner_pkg;

    localparam int PIX_COORD_W = 12;
    localparam int PIX_PAL_W   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [PIX_COORD_W-1:0] x;
        logic [PIX_COORD_W-1:0] y;
        logic [PIX_PAL_W-1:0]   palette;
    } pix_write_t;

endpackage

// File: rtl/paint_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after the
// pointer, wrapping around, so the previous winner has lowest priority.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o
);

    // Scan from pointer+1 around to pointer; first active request wins.
    always_comb begin
        int         idx;
        logic       found;
        logic [PTR_W-1:0] idx_w;
        grant_o     = '0;
        grant_idx_o = ptr_i;
        found       = 1'b0;
        idx         = 0;
        idx_w       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = (int'(ptr_i) + k) % NUM_REQ;
            idx_w = PTR_W'(idx);
            if (!found && req_i[idx_w]) begin
                grant_o[idx_w] = 1'b1;
                grant_idx_o    = idx_w;
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/paint_scheduler.sv
// Frame sequencer and framebuffer write-port arbiter. Restarts all paint
// requesters on each frame_start, shares the write port round-robin,
// signals frame_done when every requester has finished, counts overruns.
module paint_scheduler
    import runner_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int COORD_W = PIX_COORD_W,
    parameter int PAL_W   = PIX_PAL_W,
    parameter int CNT_W   = 8
) (
    input  logic                       clk_33m,
    input  logic                       reset_n,
    input  logic                       frame_start,
    output logic [NUM_REQ-1:0]         req_start,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    input  logic [NUM_REQ*PAL_W-1:0]   req_palette,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_done,
    output logic                       write_en,
    output logic [COORD_W-1:0]         write_x,
    output logic [COORD_W-1:0]         write_y,
    output logic [PAL_W-1:0]           write_palette,
    output logic                       busy,
    output logic                       frame_done,
    output logic [CNT_W-1:0]           overrun_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    sched_state_t        state_q, state_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                pend_q, pend_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    ovr_q, ovr_d;
    logic [NUM_REQ-1:0]  start_q, start_d;
    logic                busy_q, busy_d;
    logic                fdone_q, fdone_d;
    logic                wen_q, wen_d;
    logic [COORD_W-1:0]  wx_q, wx_d;
    logic [COORD_W-1:0]  wy_q, wy_d;
    logic [PAL_W-1:0]    wpal_q, wpal_d;

    logic [NUM_REQ-1:0]  arb_req;
    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                accept;
    logic [NUM_REQ-1:0]  done_set;

    // Only unfinished requesters compete, and only while painting.
    assign arb_req = req_valid & ~done_q & {NUM_REQ{state_q == RUN}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req_i       (arb_req),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign done_set  = done_q | req_done;

    // Next-state: frame sequencing, completion tracking, overrun accounting, write capture.
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        ptr_d   = accept ? grant_idx : ptr_q;
        wen_d   = accept;
        wx_d    = wx_q;
        wy_d    = wy_q;
        wpal_d  = wpal_q;
        if (accept) begin
            wx_d   = req_x[int'(grant_idx)*COORD_W +: COORD_W];
            wy_d   = req_y[int'(grant_idx)*COORD_W +: COORD_W];
            wpal_d = req_palette[int'(grant_idx)*PAL_W +: PAL_W];
        end
        case (state_q)
            IDLE: begin
                if (frame_start) state_d = START;
            end
            START: begin
                // A second frame_start here is redundant: requesters are already restarting.
                state_d = RUN;
            end
            RUN: begin
                done_d = done_set;
                if (&done_set) begin
                    // Completion beats a coincident frame_start; that start is deferred.
                    state_d = DONE;
                    pend_d  = frame_start;
                end else if (frame_start) begin
                    ovr_d   = sat_inc(ovr_q);
                    state_d = START;
                end
            end
            DONE: begin
                state_d = (pend_q || frame_start) ? START : IDLE;
                pend_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == START) done_d = '0;
        start_d = (state_d == START) ? {NUM_REQ{1'b1}} : '0;
        fdone_d = (state_d == DONE);
        busy_d  = (state_d == START) || (state_d == RUN);
    end

    // State and registered outputs; reset drops everything including an in-flight write.
    always_ff @(posedge clk_33m or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            done_q  <= '0;
            pend_q  <= 1'b0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            ovr_q   <= '0;
            start_q <= '0;
            busy_q  <= 1'b0;
            fdone_q <= 1'b0;
            wen_q   <= 1'b0;
            wx_q    <= '0;
            wy_q    <= '0;
            wpal_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            ovr_q   <= ovr_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            fdone_q <= fdone_d;
            wen_q   <= wen_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            wpal_q  <= wpal_d;
        end
    end

    assign req_start     = start_q;
    assign busy          = busy_q;
    assign frame_done    = fdone_q;
    assign overrun_count = ovr_q;
    assign write_en      = wen_q;
    assign write_x       = wx_q;
    assign write_y       = wy_q;
    assign write_palette = wpal_q;

endmodule

// File: tb/tb_paint_scheduler.sv
module tb_paint_scheduler;

    localparam int N  = 2;
    localparam int CW = 12;
    localparam int PW = 2;
    localparam int NW = 8;

    localparam int P_IDLE = 0, P_START = 1, P_RUN = 2, P_DONE = 3;

    logic            clk_33m = 1'b0;
    logic            reset_n = 1'b0;
    logic            frame_start = 1'b0;
    logic [N-1:0]    req_start;
    logic [N-1:0]    req_valid = '0;
    logic [N*CW-1:0] req_x = '0;
    logic [N*CW-1:0] req_y = '0;
    logic [N*PW-1:0] req_palette = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_done = '0;
    logic            write_en;
    logic [CW-1:0]   write_x;
    logic [CW-1:0]   write_y;
    logic [PW-1:0]   write_palette;
    logic            busy;
    logic            frame_done;
    logic [NW-1:0]   overrun_count;

    always #5 clk_33m = ~clk_33m;

    paint_scheduler #(.NUM_REQ(N), .COORD_W(CW), .PAL_W(PW), .CNT_W(NW)) dut (
        .clk_33m(clk_33m), .reset_n(reset_n), .frame_start(frame_start),
        .req_start(req_start), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
        .req_palette(req_palette), .req_ready(req_ready), .req_done(req_done),
        .write_en(write_en), .write_x(write_x), .write_y(write_y),
        .write_palette(write_palette), .busy(busy), .frame_done(frame_done),
        .overrun_count(overrun_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk_33m) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model of frame behaviour
    int       m_phase = P_IDLE;
    bit [N-1:0] m_done = '0;
    bit       m_pend = 0;
    int       m_ovr = 0;
    int       m_last = N - 1;
    typedef struct { logic [CW-1:0] x; logic [CW-1:0] y; logic [PW-1:0] p; int c; } wr_t;
    wr_t      exp_q[$];
    bit [N-1:0] acc_f = '0;
    bit [N-1:0] start_f = '0;
    int       n_wr = 0;
    int       n_fd = 0;

    // Requester behaviour
    bit       act[N];
    int       rem[N];
    int       plan[N];
    int       dens = 100;
    bit       fs_req = 0;
    bit       coincide = 0;
    bit       coinc_hit = 0;
    bit       force_valid = 0;

    int       g;
    logic [N-1:0] eg;
    wr_t      e_new;

    always @(negedge clk_33m) begin
        if (reset_n) begin
            g = -1;
            if (m_phase == P_RUN) begin
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (m_last + k) % N;
                    if (g < 0 && req_valid[i] && !m_done[i]) g = i;
                end
            end
            eg = (g >= 0) ? (N'(1) << g) : '0;
            chk("req_ready", 32'(req_ready), 32'(eg));
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            chk("req_start", 32'(req_start), (m_phase == P_START) ? 32'((1 << N) - 1) : 32'd0);
            chk("busy", 32'(busy), 32'(m_phase == P_START || m_phase == P_RUN));
            chk("frame_done", 32'(frame_done), 32'(m_phase == P_DONE));
            chk("overrun_count", 32'(overrun_count), 32'(m_ovr));
            start_f = req_start;
            if (frame_done) n_fd++;
            if (g >= 0) begin
                e_new.x = req_x[g*CW +: CW];
                e_new.y = req_y[g*CW +: CW];
                e_new.p = req_palette[g*PW +: PW];
                e_new.c = cyc;
                exp_q.push_back(e_new);
                m_last = g;
                acc_f[g] = 1'b1;
            end
            case (m_phase)
                P_IDLE:  if (frame_start) m_phase = P_START;
                P_START: begin m_done = '0; m_phase = P_RUN; end
                P_RUN: begin
                    m_done = m_done | req_done;
                    if (&m_done) begin
                        m_phase = P_DONE;
                        m_pend = frame_start;
                    end else if (frame_start) begin
                        if (m_ovr < (1 << NW) - 1) m_ovr++;
                        m_phase = P_START;
                    end
                end
                default: begin
                    m_phase = (m_pend || frame_start) ? P_START : P_IDLE;
                    m_pend = 0;
                end
            endcase
        end
    end

    // Write-port monitor: each accepted pixel must appear exactly one cycle later, in order.
    wr_t e_pop;
    always @(negedge clk_33m) begin
        if (reset_n) begin
            if (write_en) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    chk("write_unexpected", 32'd1, 32'd0);
                end else begin
                    e_pop = exp_q.pop_front();
                    chk("write_x", 32'(write_x), 32'(e_pop.x));
                    chk("write_y", 32'(write_y), 32'(e_pop.y));
                    chk("write_palette", 32'(write_palette), 32'(e_pop.p));
                    chk("write_latency", 32'(cyc - e_pop.c), 32'd1);
                end
            end else if (exp_q.size() > 0 && exp_q[0].c < cyc) begin
                chk("write_missing", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
        end
    end

    // Requester stimulus, driven just after each active edge.
    always @(posedge clk_33m) begin
        #1;
        if (reset_n) begin
            logic [CW-1:0] xv;
            frame_start = 1'b0;
            req_done = '0;
            for (int i = 0; i < N; i++) begin
                if (start_f[i]) begin
                    rem[i] = plan[i];
                    act[i] = 1'b1;
                    req_valid[i] = 1'b0;
                end else if (acc_f[i]) begin
                    rem[i]--;
                    req_valid[i] = 1'b0;
                end
                if (act[i]) begin
                    if (rem[i] == 0) begin
                        req_done[i] = 1'b1;
                        act[i] = 1'b0;
                    end else if (!req_valid[i] && ($urandom % 100) < dens) begin
                        xv = CW'($urandom);
                        xv[CW-1] = 1'(i);
                        req_valid[i] = 1'b1;
                        req_x[i*CW +: CW] = xv;
                        req_y[i*CW +: CW] = CW'($urandom);
                        req_palette[i*PW +: PW] = PW'($urandom);
                    end
                end
                if (force_valid) req_valid[i] = 1'b1;
            end
            acc_f = '0;
            start_f = '0;
            if (coincide && (|req_done) && !act[0] && !act[1]) begin
                frame_start = 1'b1;
                coincide = 0;
                coinc_hit = 1;
            end
            if (fs_req) begin
                frame_start = 1'b1;
                fs_req = 0;
            end
        end
    end

    task automatic reset_models();
        m_phase = P_IDLE; m_done = '0; m_pend = 0; m_ovr = 0; m_last = N - 1;
        exp_q.delete();
        acc_f = '0; start_f = '0;
    endtask

    task automatic reset_reqs();
        for (int i = 0; i < N; i++) begin act[i] = 0; rem[i] = 0; end
        req_valid = '0; req_done = '0; frame_start = 1'b0; fs_req = 0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int target;
        int k;
        target = n_fd + n;
        k = 0;
        while (n_fd < target && k < budget) begin
            @(negedge clk_33m);
            k++;
        end
        if (n_fd < target) chk("frame_timeout", 32'(n_fd), 32'(target));
        repeat (3) @(negedge clk_33m);
    endtask

    int w0;
    int o0;

    initial begin
        for (int i = 0; i < N; i++) begin act[i] = 0; rem[i] = 0; plan[i] = 0; end
        reset_n = 1'b0;
        reset_models();
        repeat (3) @(posedge clk_33m);
        @(negedge clk_33m);
        chk("rst_req_start", 32'(req_start), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_write_x", 32'(write_x), 32'd0);
        chk("rst_write_y", 32'(write_y), 32'd0);
        chk("rst_write_pal", 32'(write_palette), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overrun", 32'(overrun_count), 32'd0);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk_33m);

        // Single frame: req0 streams 3 pixels, req1 finishes immediately
        plan[0] = 3; plan[1] = 0; dens = 100;
        w0 = n_wr;
        fs_req = 1;
        wait_frames(1, 100);
        chk("t1_write_count", 32'(n_wr - w0), 32'd3);

        // Both requesters continuously valid: alternating grants
        plan[0] = 6; plan[1] = 6; dens = 100;
        w0 = n_wr;
        fs_req = 1;
        wait_frames(1, 200);
        chk("t2_write_count", 32'(n_wr - w0), 32'd12);

        // Randomised frames
        for (int f = 0; f < 8; f++) begin
            plan[0] = $urandom_range(0, 7);
            plan[1] = $urandom_range(0, 7);
            dens = $urandom_range(20, 100);
            w0 = n_wr;
            fs_req = 1;
            wait_frames(1, 400);
            chk("rand_write_count", 32'(n_wr - w0), 32'(plan[0] + plan[1]));
        end

        // frame_start coincident with the last done: completion wins, then restart
        plan[0] = 3; plan[1] = 1; dens = 100;
        o0 = int'(overrun_count);
        coinc_hit = 0;
        coincide = 1;
        fs_req = 1;
        wait_frames(2, 300);
        chk("t4_coincide_hit", 32'(coinc_hit), 32'd1);
        chk("t4_overrun_same", 32'(overrun_count), 32'(o0));
        coincide = 0;

        // Overrun: restart while req1 still painting, then saturate
        plan[0] = 2; plan[1] = 40; dens = 100;
        fs_req = 1;
        repeat (12) @(negedge clk_33m);
        fs_req = 1;
        repeat (4) @(negedge clk_33m);
        chk("t3_overrun_one", 32'(overrun_count), 32'd1);
        for (int r = 0; r < 258; r++) begin
            fs_req = 1;
            repeat (4) @(negedge clk_33m);
        end
        chk("t3_overrun_sat", 32'(overrun_count), 32'hFF);
        plan[0] = 1; plan[1] = 1;
        fs_req = 1;
        wait_frames(1, 200);
        chk("t3_overrun_hold", 32'(overrun_count), 32'hFF);

        // Reset in the middle of a busy frame with requests pending
        plan[0] = 50; plan[1] = 50; dens = 100;
        fs_req = 1;
        repeat (8) @(negedge clk_33m);
        chk("t5_pre_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        reset_models();
        #1;
        chk("t5_write_en", 32'(write_en), 32'd0);
        chk("t5_req_ready", 32'(req_ready), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_overrun", 32'(overrun_count), 32'd0);
        reset_reqs();
        repeat (2) @(posedge clk_33m);
        @(negedge clk_33m);
        #2 reset_n = 1'b1;
        force_valid = 1;
        repeat (6) begin
            @(negedge clk_33m);
            chk("t5_no_write", 32'(write_en), 32'd0);
            chk("t5_idle_ready", 32'(req_ready), 32'd0);
        end
        force_valid = 0;
        plan[0] = 1; plan[1] = 1;
        w0 = n_wr;
        fs_req = 1;
        wait_frames(1, 100);
        chk("t5_after_writes", 32'(n_wr - w0), 32'd2);

        repeat (5) @(negedge clk_33m);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
